// File: rtl/mod10_counter.sv
// -----------------------------------------------------------------------------
// mod10_counter
//
// Free-running modulo-N up counter. It steps on every rising clk edge outside
// reset and runs 0, 1, ..., MODULUS-1, 0, 1, ... with no enable, load or
// direction control. If the register ever holds a value that is out of range,
// the next clock edge outside reset returns it to 0.
//
// Parameters
//   MODULUS : count sequence length. The counter runs 0 .. MODULUS-1.
//             The default is 10.
//   WIDTH   : bit width of count. The default is 4.
//
// Ports (in this order, so a positional hookup of the first three is legal)
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous reset, active-low (0 = reset asserted)
//   count out  WIDTH  current counter value, driven straight from the register
//   tc    out  1      terminal count, high while count == MODULUS-1
// -----------------------------------------------------------------------------
module mod10_counter #(
  parameter int MODULUS = 10,
  parameter int WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  // Refuse to elaborate a counter that cannot hold its own sequence.
  if (MODULUS < 2 || (WIDTH < 31 && (1 << WIDTH) < MODULUS)) begin : g_bad_params
    $error("mod10_counter: need MODULUS >= 2 and 2**WIDTH >= MODULUS");
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;

  // One comparison covers both cases. At LAST the counter wraps normally.
  // Above LAST the value is illegal and also goes back to 0, so an upset
  // register never walks through codes outside the sequence.
  always_comb begin
    // NOTE: the default is assigned first so every path drives the signal and no latch is inferred.
    w_count_nxt = r_count + 1'b1;
    if (r_count >= LAST) begin
      w_count_nxt = '0;
    end
  end

  // NOTE: the reset is asynchronous, so count clears as soon as rst falls,
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: use non-blocking assignment for all sequential state.
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign count = r_count;

  // count is 0 while reset is asserted, and LAST is never 0, so tc is
  // guaranteed low during reset.
  assign tc = (r_count == LAST);

endmodule

// File: tb/tb_mod10_counter.sv
// -----------------------------------------------------------------------------
// tb_mod10_counter
//
// Self-checking bench for mod10_counter with its default parameters
// (MODULUS = 10, WIDTH = 4). The clock has a period of 10 and rises at
// 5, 15, 25, ...
//
// The bench runs in these phases:
//   1. Power-up reset and the reference timeline.
//   2. A table of per-edge expectations around an asynchronous reset and a
//      release that lands on a clock edge.
//   3. Forced illegal register values.
//   4. Randomised reset pulses checked against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_mod10_counter;

  localparam int MOD = 10;

  logic       clk;
  logic       rst;
  logic [3:0] count;
  logic       tc;

  int n_checks = 0;
  int n_pass   = 0;

  mod10_counter #(.MODULUS(MOD), .WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .tc    (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       drv_rst;    // rst value driven at the falling edge before the check
    logic [3:0] exp_count;  // count expected just after the next rising edge
    logic       exp_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Apply one record. The caller starts at a falling edge and is left at the
  // next falling edge.
  task automatic run_vec(input int idx);
    rst = vecs[idx].drv_rst;
    @(posedge clk);
    #1;
    check($sformatf("vec%0d_count", idx), int'(count), int'(vecs[idx].exp_count));
    check($sformatf("vec%0d_tc", idx),    int'(tc),    int'(vecs[idx].exp_tc));
    @(negedge clk);
  endtask

  int model;
  int ill_vals[3] = '{10, 12, 15};

  initial begin
    // Records 0..8: counting from a release at t=10, giving 1..9 after edges 15..95.
    for (int k = 1; k <= 9; k++) vecs.push_back('{1'b1, 4'(k), k == MOD - 1});
    // Records 9..20: after the restart, 4..9, then a wrap to 0, then 1..5.
    for (int k = 4; k <= 15; k++) vecs.push_back('{1'b1, 4'(k % MOD), (k % MOD) == MOD - 1});

    // ---------------- power-up ----------------
    rst = 1'b0;
    #1;
    check("por_count", int'(count), 0);
    check("por_tc",    int'(tc),    0);
    @(posedge clk);  // t=5, reset is still held
    #1;
    check("por_edge_count", int'(count), 0);
    check("por_edge_tc",    int'(tc),    0);
    @(negedge clk);  // t=10

    // ---------------- first count run ----------------
    for (int i = 0; i < 9; i++) run_vec(i);  // ends at t=100 with count=9

    // ---------------- mid-run asynchronous reset ----------------
    rst = 1'b0;  // t=100, no clock edge here
    #1;
    check("async_clr_count", int'(count), 0);
    check("async_clr_tc",    int'(tc),    0);
    @(posedge clk);  // t=105
    #1;
    check("hold105_count", int'(count), 0);
    @(posedge clk);  // t=115, release lands on this edge
    // The non-blocking drive lands after the counter has sampled this edge,
    // which models a release coincident with it: the count must stay 0.
    rst <= 1'b1;
    #1;
    check("hold115_count", int'(count), 0);
    for (int k = 1; k <= 3; k++) begin  // edges 125, 135, 145
      @(posedge clk);
      #1;
      check($sformatf("restart%0d_count", k), int'(count), k);
      check($sformatf("restart%0d_tc", k),    int'(tc),    0);
    end
    @(negedge clk);  // t=150

    // ---------------- continue through 9 and the wrap ----------------
    for (int i = 9; i < vecs.size(); i++) run_vec(i);

    // ---------------- illegal register values ----------------
    foreach (ill_vals[j]) begin
      force dut.r_count = 4'(ill_vals[j]);
      #1;
      check($sformatf("ill%0d_tc_hold", ill_vals[j]), int'(tc), 0);
      release dut.r_count;
      @(posedge clk);
      #1;
      check($sformatf("ill%0d_count", ill_vals[j]), int'(count), 0);
      check($sformatf("ill%0d_tc", ill_vals[j]),    int'(tc),    0);
      @(negedge clk);
    end

    // ---------------- randomised reset pulses against a model ----------------
    model = 0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 9) != 0);
      if (!rst) begin
        model = 0;
        #1;
        check("rnd_async_count", int'(count), 0);
        check("rnd_async_tc",    int'(tc),    0);
      end
      @(posedge clk);
      if (rst) model = (model + 1) % MOD;
      #1;
      check("rnd_count", int'(count), model);
      check("rnd_tc",    int'(tc),    int'(model == MOD - 1));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod10_counter.md
MOD10_COUNTER -- requirements
Module: mod10_counter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock is `clk`, reset is `rst`.
REQ-002 Parameter: MODULUS, default 10, the count sequence length (0 .. MODULUS-1).
REQ-003 Parameter: WIDTH, default 4, the bit width of `count`.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  asynchronous reset, active-low (0 = reset asserted).
REQ-006 Port: count  output  WIDTH  current counter value, unsigned, driven directly from a register.
REQ-007 Port: tc  output  1  terminal count, combinational, high while count == MODULUS-1.
REQ-008 Port order SHALL be clk, rst, count, tc, so that a positional connection of the first three ports is valid and tc may be left unconnected.

Function
REQ-009 On each rising clk edge with rst=1, count SHALL advance by exactly 1 when count < MODULUS-1.
REQ-010 On a rising clk edge with rst=1 and count == MODULUS-1 (9 by default), count SHALL wrap to 0 on that same edge, with no extra cycle of latency.
REQ-011 The default sequence SHALL be 0,1,2,...,9,0,1,... with exactly one step per enabled clock edge and no skipped or repeated values.
REQ-012 Count latency SHALL be one clock: the new value is visible immediately after the active edge.
REQ-013 If count ever holds a value >= MODULUS (illegal state), the next rising edge with rst=1 SHALL load 0.
REQ-014 tc SHALL be 1 exactly when count == MODULUS-1 and 0 otherwise, including during reset.
REQ-015 Values 10..15 SHALL never be produced on count from any legal state.
REQ-016 Elaboration SHALL fail when MODULUS < 2 or when 2**WIDTH < MODULUS.
REQ-017 There SHALL be no enable, load or direction input; the counter runs on every clock edge outside reset.

Reset
REQ-018 While rst=0, count SHALL be 0 and tc SHALL be 0, independent of clk.
REQ-019 Assertion of rst (falling edge) SHALL clear count immediately, without waiting for a clock edge, including mid-sequence.
REQ-020 After rst rises to 1, the first rising clk edge SHALL take count from 0 to 1.
REQ-021 Release of rst coincident with a rising clk edge SHALL leave count at 0 for that edge; counting SHALL start on the next edge.
REQ-022 Reset SHALL have priority over counting and wrap at all times.

Verification
REQ-023 Power-up: clk period 10, rises at 5, 15, 25, ...; rst=0 from t=0 to t=10 -> count=0 and tc=0 throughout, including at the edge at t=5.
REQ-024 Count run: release rst at t=10 -> count=1 after t=15, 2 after t=25, ..., 9 after t=95 with tc=1 only while count=9.
REQ-025 Wrap: continue from count=9 -> count=0 on the next edge and tc returns to 0; the sequence then continues 1,2,...
REQ-026 Mid-run reset: drive rst=0 at t=100 with count nonzero -> count=0 at t=100 without a clock edge, and it holds 0 for the edges at t=105 and t=115.
REQ-027 Restart: rst=1 at t=115 -> count=1 after t=125, 2 after t=135, 3 after t=145.
REQ-028 Illegal state: force count=12, then release it with rst=1 -> count=0 after the next edge and tc=0.
